// File: rtl/raster_scheduler.sv
// rtl/raster_scheduler.sv - per-frame triangle fetch/issue scheduler with optional back-buffer clear
// Define RASTER_SCHED_CLEAR_EN to include the back-buffer clear pass before triangle fetch.
module raster_scheduler #(
  parameter int WIDTH   = 360,
  parameter int HEIGHT  = 360,
  parameter int NUM_TRI = 64,
  parameter int ROM_LAT = 2,
  localparam int TW     = $clog2(NUM_TRI)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          new_frame,
  input  logic [TW:0]   tri_count_in,
  input  logic          raster_ready_in,
  output logic [TW-1:0] tri_addr_out,
  output logic          tri_valid_out,
  output logic          obj_done_out,
  output logic          swap_out,
  output logic [16:0]   clear_addr_out,
  output logic          clear_we_out,
  output logic [16:0]   clear_data_out,
  output logic          busy_out,
  output logic [7:0]    overrun_out
);

  localparam int RW = $clog2(ROM_LAT + 1);
  localparam logic [RW-1:0] ROM_LAST = RW'(ROM_LAT - 1);
  localparam logic [TW:0]   MAX_CNT  = (TW + 1)'(NUM_TRI);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT_ROM, ISSUE, WAIT_RAST, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW:0]   idx_q, idx_d, count_q, count_d;
  logic [TW-1:0] addr_q, addr_d;
  logic [RW-1:0] rom_cnt_q, rom_cnt_d;
  logic          seen_low_q, seen_low_d;
  logic          swap_q, swap_d;
  logic [7:0]    overrun_q, overrun_d;
  logic          idle_like;

`ifdef RASTER_SCHED_CLEAR_EN
  localparam logic [16:0] CLEAR_LAST = 17'(WIDTH * HEIGHT - 1);
  logic [16:0] clr_q, clr_d;
`endif

  assign idle_like = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    addr_d     = addr_q;
    rom_cnt_d  = rom_cnt_q;
    seen_low_d = seen_low_q;
    swap_d     = 1'b0;
    overrun_d  = overrun_q;
`ifdef RASTER_SCHED_CLEAR_EN
    clr_d      = clr_q;
`endif
    // A frame start that arrives while busy is dropped, only counted.
    if (new_frame && !idle_like && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    case (state_q)
      IDLE, DONE: begin
        if (new_frame) begin
          swap_d  = (state_q == DONE);
          count_d = (tri_count_in > MAX_CNT) ? MAX_CNT : tri_count_in;
          idx_d   = '0;
`ifdef RASTER_SCHED_CLEAR_EN
          clr_d   = '0;
          state_d = CLEAR;
`else
          state_d = FETCH;
`endif
        end
      end
      CLEAR: begin
`ifdef RASTER_SCHED_CLEAR_EN
        if (clr_q == CLEAR_LAST) begin
          clr_d   = '0;
          state_d = FETCH;
        end else begin
          clr_d = clr_q + 17'd1;
        end
`else
        state_d = FETCH;
`endif
      end
      FETCH: begin
        if (idx_q == count_q) begin
          state_d = DONE;
        end else begin
          addr_d    = idx_q[TW-1:0];
          rom_cnt_d = '0;
          state_d   = WAIT_ROM;
        end
      end
      WAIT_ROM: begin
        if (rom_cnt_q == ROM_LAST) state_d = ISSUE;
        else rom_cnt_d = rom_cnt_q + RW'(1);
      end
      ISSUE: begin
        if (raster_ready_in) begin
          idx_d      = idx_q + (TW + 1)'(1);
          seen_low_d = 1'b0;
          state_d    = WAIT_RAST;
        end
      end
      WAIT_RAST: begin
        // Rasterizer acknowledges completion by a low-then-high ready.
        if (!raster_ready_in) seen_low_d = 1'b1;
        else if (seen_low_q) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      rom_cnt_q  <= '0;
      seen_low_q <= 1'b0;
      swap_q     <= 1'b0;
      overrun_q  <= '0;
`ifdef RASTER_SCHED_CLEAR_EN
      clr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      rom_cnt_q  <= rom_cnt_d;
      seen_low_q <= seen_low_d;
      swap_q     <= swap_d;
      overrun_q  <= overrun_d;
`ifdef RASTER_SCHED_CLEAR_EN
      clr_q      <= clr_d;
`endif
    end
  end

  assign tri_addr_out   = addr_q;
  assign tri_valid_out  = (state_q == ISSUE);
  assign obj_done_out   = tri_valid_out && ((idx_q + (TW + 1)'(1)) == count_q);
  assign swap_out       = swap_q;
  assign busy_out       = !idle_like;
  assign overrun_out    = overrun_q;
  assign clear_data_out = {8'h00, 9'h1FF};
`ifdef RASTER_SCHED_CLEAR_EN
  assign clear_addr_out = clr_q;
  assign clear_we_out   = (state_q == CLEAR);
`else
  assign clear_addr_out = '0;
  assign clear_we_out   = 1'b0;
`endif

endmodule

// File: tb/tb_raster_scheduler.sv
// tb/tb_raster_scheduler.sv - self-checking bench for raster_scheduler
// Expected per-frame behaviour comes from a frame-level model of clears, triangles, swaps and overruns.
module tb_raster_scheduler;

  localparam int W  = 6;
  localparam int H  = 4;
  localparam int NT = 8;
  localparam int RL = 2;
  localparam int TW = $clog2(NT);
`ifdef RASTER_SCHED_CLEAR_EN
  localparam int CLR_N = W * H;
`else
  localparam int CLR_N = 0;
`endif

  logic          clk, rst, new_frame, raster_ready;
  logic [TW:0]   tri_count;
  logic [TW-1:0] tri_addr;
  logic          tri_valid, obj_done, swap, clear_we, busy;
  logic [16:0]   clear_addr, clear_data;
  logic [7:0]    overrun;

  raster_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_TRI(NT), .ROM_LAT(RL)) dut (
    .clk_in(clk), .rst_in(rst), .new_frame(new_frame), .tri_count_in(tri_count),
    .raster_ready_in(raster_ready), .tri_addr_out(tri_addr), .tri_valid_out(tri_valid),
    .obj_done_out(obj_done), .swap_out(swap), .clear_addr_out(clear_addr),
    .clear_we_out(clear_we), .clear_data_out(clear_data), .busy_out(busy),
    .overrun_out(overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int drop_len = 1;
  int stall_len = 0;
  int stall_id = 0;
  int ovr_model = 0;
  bit frame_done = 1'b0;

  int clr_q[$], iss_addr_q[$], iss_done_q[$], gap_q[$], lat_q[$], run_q[$];
  int swap_cnt = 0, swap_lat = 0, stab_err = 0, done_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rasterizer: optional initial stall, then drops ready for drop_len cycles after each accept.
  initial begin
    int hold, seen_id;
    hold = 0;
    seen_id = 0;
    raster_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tri_valid && stall_id != seen_id) begin
        seen_id = stall_id;
        hold = stall_len;
      end
      if (hold > 0) begin
        raster_ready = 1'b0;
        hold--;
      end else begin
        raster_ready = 1'b1;
      end
      if (tri_valid && raster_ready) hold = drop_len;
    end
  end

  // Monitor: records clears, handshakes, swaps and timing for the frame-level checks.
  initial begin
    int cyc, acc_cyc, hs_cyc, run, prev_addr;
    bit prev_valid, have_hs;
    cyc = 0; acc_cyc = 0; hs_cyc = 0; run = 0; prev_addr = 0;
    prev_valid = 1'b0; have_hs = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst && new_frame && !busy) begin
        acc_cyc = cyc;
        have_hs = 1'b0;
      end
      if (clear_we) clr_q.push_back(int'(clear_addr));
      if (swap) begin
        swap_cnt++;
        swap_lat = cyc - acc_cyc;
      end
      if (obj_done && !tri_valid) done_err++;
      if (tri_valid) begin
        if (prev_valid && int'(tri_addr) != prev_addr) stab_err++;
        if (!prev_valid) begin
          if (have_hs) gap_q.push_back(cyc - hs_cyc);
          else lat_q.push_back(cyc - acc_cyc);
          run = 0;
        end
        run++;
        if (raster_ready && rst) begin
          iss_addr_q.push_back(int'(tri_addr));
          iss_done_q.push_back(int'(obj_done));
          run_q.push_back(run);
          hs_cyc = cyc;
          have_hs = 1'b1;
        end
      end
      prev_valid = tri_valid;
      prev_addr = int'(tri_addr);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int cnt, input int drop, input int stall, input int mode);
    int n, to, bad, clr_b, iss_b, gap_b, lat_b, run_b, swp_b;
    bit exp_swap, pulse;
    n = (cnt > NT) ? NT : cnt;
    exp_swap = frame_done;
    clr_b = clr_q.size(); iss_b = iss_addr_q.size(); gap_b = gap_q.size();
    lat_b = lat_q.size(); run_b = run_q.size(); swp_b = swap_cnt;
    drop_len = drop;
    if (stall > 0) begin
      stall_len = stall;
      stall_id++;
    end
    @(negedge clk);
    new_frame = 1'b1;
    tri_count = (TW + 1)'(cnt);
    to = 0;
    while (to < 5000) begin
      @(negedge clk);
      new_frame = 1'b0;
      if (busy !== 1'b1) break;
      pulse = (mode == 1) ? ($urandom_range(0, 7) == 0) : ((mode == 2) ? (to % 2 == 0) : 1'b0);
      if (pulse) begin
        new_frame = 1'b1;
        ovr_model++;
      end
      to++;
    end
    #2;
    frame_done = 1'b1;
    check("frame_timeout", int'(to < 5000), 1);
    check("clear_count", clr_q.size() - clr_b, CLR_N);
    bad = 0;
    for (int i = 0; i < clr_q.size() - clr_b; i++) if (clr_q[clr_b + i] != i) bad++;
    check("clear_order", bad, 0);
    check("tri_issued", iss_addr_q.size() - iss_b, n);
    bad = 0;
    for (int i = 0; i < iss_addr_q.size() - iss_b; i++)
      if (iss_addr_q[iss_b + i] != i || iss_done_q[iss_b + i] != int'(i == n - 1)) bad++;
    check("tri_order_done", bad, 0);
    check("first_valid_seen", lat_q.size() - lat_b, (n > 0) ? 1 : 0);
    if (lat_q.size() > lat_b) check("first_latency", lat_q[lat_b], CLR_N + 2 + RL);
    check("gap_count", gap_q.size() - gap_b, (n > 0) ? n - 1 : 0);
    bad = 0;
    for (int i = gap_b; i < gap_q.size(); i++) if (gap_q[i] != drop + 3 + RL) bad++;
    check("gap_len", bad, 0);
    bad = 0;
    for (int i = 0; i < run_q.size() - run_b; i++)
      if (run_q[run_b + i] != ((i == 0 && stall > 0) ? stall + 1 : 1)) bad++;
    check("valid_run", bad, 0);
    check("swap_count", swap_cnt - swp_b, int'(exp_swap));
    if (swap_cnt > swp_b) check("swap_latency", swap_lat, 1);
    check("overrun", int'(overrun), (ovr_model > 255) ? 255 : ovr_model);
  endtask

  initial begin
    int to, swp_b;
    rst = 1'b0;
    new_frame = 1'b0;
    tri_count = '0;
    repeat (3) @(negedge clk);
    check("rst_hold_valid", int'(tri_valid), 0);
    check("rst_hold_busy", int'(busy), 0);
    check("rst_hold_swap", int'(swap), 0);
    check("rst_hold_clear_we", int'(clear_we), 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_valid", int'(tri_valid), 0);
    check("reset_done", int'(obj_done), 0);
    check("reset_swap", int'(swap), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_addr", int'(tri_addr), 0);
    check("reset_clear_addr", int'(clear_addr), 0);
    check("reset_clear_data", int'(clear_data), 'h1FF);
    check("reset_no_swap_exit", swap_cnt, 0);

    run_frame(3, 1, 0, 0);
    run_frame(5, 2, 0, 0);
    run_frame(4, 1, 10, 0);
    run_frame(0, 1, 0, 0);
    run_frame(NT + 1, 3, 0, 0);
    for (int k = 0; k < 6; k++)
      run_frame(int'($urandom_range(0, NT + 2)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 3)), 1);
    run_frame(2, 1, 700, 2);

    stall_len = 6;
    stall_id++;
    drop_len = 1;
    @(negedge clk);
    new_frame = 1'b1;
    tri_count = (TW + 1)'(3);
    @(negedge clk);
    new_frame = 1'b0;
    to = 0;
    while (tri_valid !== 1'b1 && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("reach_issue", int'(to < 200), 1);
    swp_b = swap_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(tri_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_clear_we", int'(clear_we), 0);
    rst = 1'b1;
    ovr_model = 0;
    frame_done = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    check("midrst_no_swap", swap_cnt - swp_b, 0);
    run_frame(3, 2, 0, 0);

    check("addr_stability", stab_err, 0);
    check("done_without_valid", done_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
